// File: rtl/sys_ctrl_pkg.sv
// Shared types and constants for the UART command sequencer (sys_ctrl_rx).
package sys_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B,
    ALU_FUN, ALU_WAIT, TX_LSB, TX_MSB
  } state_t;

  typedef enum logic [1:0] {P_IDLE, P_LSB, P_MSB} push_state_t;

  localparam logic [7:0] OP_WRITE  = 8'hAA;
  localparam logic [7:0] OP_READ   = 8'hBB;
  localparam logic [7:0] OP_ALU_AB = 8'hCC;
  localparam logic [7:0] OP_ALU    = 8'hDD;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  // States that are waiting for the next frame byte from the receiver.
  function automatic logic is_byte_wait(state_t s);
    return (s == WR_ADDR) || (s == WR_DATA) || (s == RD_ADDR) ||
           (s == OP_A) || (s == OP_B) || (s == ALU_FUN);
  endfunction

endpackage

// File: rtl/sys_ctrl_rx_if.sv
// Bus bundle between the command sequencer and the UART RX, register file, ALU and TX FIFO.
interface sys_ctrl_rx_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0]   rx_data;
  logic                rx_data_valid;
  logic                rf_wr_en;
  logic                rf_rd_en;
  logic [ADDR_W-1:0]   rf_addr;
  logic [DATA_W-1:0]   rf_wr_data;
  logic [DATA_W-1:0]   rf_rd_data;
  logic                rf_rd_valid;
  logic                alu_en;
  logic [3:0]          alu_fun;
  logic [2*DATA_W-1:0] alu_out;
  logic                alu_out_valid;
  logic                tx_wr_en;
  logic [DATA_W-1:0]   tx_wr_data;
  logic                tx_full;
  logic                busy;
  logic                frame_err;

  modport master (
    input  rx_data, rx_data_valid, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_full,
    output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, tx_wr_en, tx_wr_data,
           busy, frame_err
  );

  modport slave (
    output rx_data, rx_data_valid, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_full,
    input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, tx_wr_en, tx_wr_data,
           busy, frame_err
  );

endinterface

// File: rtl/tx_byte_pusher.sv
// Pushes a 1- or 2-byte result into the TX FIFO (LSB first), stalling while the FIFO is full.
module tx_byte_pusher
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                single,
  input  logic [2*DATA_W-1:0] payload,
  input  logic                tx_full,
  output logic                tx_wr_en,
  output logic [DATA_W-1:0]   tx_wr_data,
  output logic                done
);

  push_state_t       pst, pst_nxt;
  logic [DATA_W-1:0] lo_q, hi_q, lo_nxt, hi_nxt, data_nxt;
  logic              wr_en_nxt, done_nxt;

  // A single-byte payload is parked in the MSB slot so it goes out as the final push.
  always_comb begin
    pst_nxt   = pst;
    lo_nxt    = lo_q;
    hi_nxt    = hi_q;
    data_nxt  = tx_wr_data;
    wr_en_nxt = 1'b0;
    done_nxt  = 1'b0;
    case (pst)
      P_IDLE: if (start) begin
        lo_nxt = payload[DATA_W-1:0];
        hi_nxt = single ? payload[DATA_W-1:0] : payload[2*DATA_W-1:DATA_W];
        if (tx_full) begin
          pst_nxt = single ? P_MSB : P_LSB;
        end else begin
          wr_en_nxt = 1'b1;
          data_nxt  = payload[DATA_W-1:0];
          done_nxt  = single;
          pst_nxt   = single ? P_IDLE : P_MSB;
        end
      end
      P_LSB: if (!tx_full) begin
        wr_en_nxt = 1'b1;
        data_nxt  = lo_q;
        pst_nxt   = P_MSB;
      end
      P_MSB: if (!tx_full) begin
        wr_en_nxt = 1'b1;
        data_nxt  = hi_q;
        done_nxt  = 1'b1;
        pst_nxt   = P_IDLE;
      end
      default: pst_nxt = P_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pst        <= P_IDLE;
      lo_q       <= '0;
      hi_q       <= '0;
      tx_wr_en   <= 1'b0;
      tx_wr_data <= '0;
      done       <= 1'b0;
    end else begin
      pst        <= pst_nxt;
      lo_q       <= lo_nxt;
      hi_q       <= hi_nxt;
      tx_wr_en   <= wr_en_nxt;
      tx_wr_data <= data_nxt;
      done       <= done_nxt;
    end
  end

endmodule

// File: rtl/sys_ctrl_rx.sv
// Command sequencer: decodes UART byte frames into register-file / ALU operations and TX responses.
// Optional inter-byte timeout enabled by defining SYS_CTRL_TIMEOUT_EN.
module sys_ctrl_rx
  import sys_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic           clk,
  input  logic           rstn,
  sys_ctrl_rx_if.master  bus
);

  state_t              state, state_nxt;
  logic                rf_wr_en_q, rf_rd_en_q, alu_en_q, frame_err_q, busy_q;
  logic                rf_wr_en_nxt, rf_rd_en_nxt, alu_en_nxt, frame_err_nxt;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_nxt;
  logic [DATA_W-1:0]   rf_wr_data_q, rf_wr_data_nxt;
  logic [3:0]          alu_fun_q, alu_fun_nxt;
  logic                push_start, push_single, push_done, timeout;
  logic [2*DATA_W-1:0] push_payload;
  logic                tx_wr_en;
  logic [DATA_W-1:0]   tx_wr_data;

`ifdef SYS_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                           to_cnt <= '0;
    else if (bus.rx_data_valid || !is_byte_wait(state)) to_cnt <= '0;
    else if (!timeout)                                   to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = is_byte_wait(state) && !bus.rx_data_valid &&
                   (to_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    rf_wr_en_nxt   = 1'b0;
    rf_rd_en_nxt   = 1'b0;
    alu_en_nxt     = 1'b0;
    frame_err_nxt  = 1'b0;
    rf_addr_nxt    = rf_addr_q;
    rf_wr_data_nxt = rf_wr_data_q;
    alu_fun_nxt    = alu_fun_q;
    push_start     = 1'b0;
    push_single    = 1'b0;
    push_payload   = bus.alu_out;
    case (state)
      IDLE: if (bus.rx_data_valid) begin
        case (bus.rx_data)
          DATA_W'(OP_WRITE):  state_nxt = WR_ADDR;
          DATA_W'(OP_READ):   state_nxt = RD_ADDR;
          DATA_W'(OP_ALU_AB): state_nxt = OP_A;
          DATA_W'(OP_ALU):    state_nxt = ALU_FUN;
          default:            frame_err_nxt = 1'b1;
        endcase
      end
      WR_ADDR: if (bus.rx_data_valid) begin
        rf_addr_nxt = bus.rx_data[ADDR_W-1:0];
        state_nxt   = WR_DATA;
      end
      WR_DATA: if (bus.rx_data_valid) begin
        rf_wr_data_nxt = bus.rx_data;
        rf_wr_en_nxt   = 1'b1;
        state_nxt      = IDLE;
      end
      RD_ADDR: if (bus.rx_data_valid) begin
        rf_addr_nxt  = bus.rx_data[ADDR_W-1:0];
        rf_rd_en_nxt = 1'b1;
        state_nxt    = RD_WAIT;
      end
      // Bytes arriving while a result is pending are dropped; commands are not pipelined.
      RD_WAIT: if (bus.rf_rd_valid) begin
        push_start   = 1'b1;
        push_single  = 1'b1;
        push_payload = {{DATA_W{1'b0}}, bus.rf_rd_data};
        state_nxt    = TX_MSB;
      end
      OP_A: if (bus.rx_data_valid) begin
        rf_addr_nxt    = ADDR_W'(OPA_ADDR);
        rf_wr_data_nxt = bus.rx_data;
        rf_wr_en_nxt   = 1'b1;
        state_nxt      = OP_B;
      end
      OP_B: if (bus.rx_data_valid) begin
        rf_addr_nxt    = ADDR_W'(OPB_ADDR);
        rf_wr_data_nxt = bus.rx_data;
        rf_wr_en_nxt   = 1'b1;
        state_nxt      = ALU_FUN;
      end
      ALU_FUN: if (bus.rx_data_valid) begin
        alu_fun_nxt = bus.rx_data[3:0];
        alu_en_nxt  = 1'b1;
        state_nxt   = ALU_WAIT;
      end
      ALU_WAIT: if (bus.alu_out_valid) begin
        push_start = 1'b1;
        state_nxt  = TX_LSB;
      end
      TX_LSB:  if (tx_wr_en)  state_nxt = TX_MSB;
      TX_MSB:  if (push_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (timeout) begin
      state_nxt     = IDLE;
      frame_err_nxt = 1'b1;
      rf_wr_en_nxt  = 1'b0;
      rf_rd_en_nxt  = 1'b0;
      alu_en_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      alu_en_q     <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      alu_fun_q    <= '0;
    end else begin
      state        <= state_nxt;
      rf_wr_en_q   <= rf_wr_en_nxt;
      rf_rd_en_q   <= rf_rd_en_nxt;
      alu_en_q     <= alu_en_nxt;
      frame_err_q  <= frame_err_nxt;
      busy_q       <= (state_nxt != IDLE);
      rf_addr_q    <= rf_addr_nxt;
      rf_wr_data_q <= rf_wr_data_nxt;
      alu_fun_q    <= alu_fun_nxt;
    end
  end

  tx_byte_pusher #(.DATA_W(DATA_W)) u_pusher (
    .clk        (clk),
    .rstn       (rstn),
    .start      (push_start),
    .single     (push_single),
    .payload    (push_payload),
    .tx_full    (bus.tx_full),
    .tx_wr_en   (tx_wr_en),
    .tx_wr_data (tx_wr_data),
    .done       (push_done)
  );

  assign bus.rf_wr_en   = rf_wr_en_q;
  assign bus.rf_rd_en   = rf_rd_en_q;
  assign bus.rf_addr    = rf_addr_q;
  assign bus.rf_wr_data = rf_wr_data_q;
  assign bus.alu_en     = alu_en_q;
  assign bus.alu_fun    = alu_fun_q;
  assign bus.tx_wr_en   = tx_wr_en;
  assign bus.tx_wr_data = tx_wr_data;
  assign bus.busy       = busy_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_sys_ctrl_rx.sv
// Directed bench for sys_ctrl_rx with an event scoreboard on the strobe outputs.
module tb_sys_ctrl_rx;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int TO     = 16;

  typedef struct packed {
    logic [2:0] k;
    logic [7:0] a;
    logic [7:0] d;
  } ev_t;

  localparam logic [2:0] EV_WR = 3'd1, EV_RD = 3'd2, EV_ALU = 3'd3, EV_TX = 3'd4, EV_ERR = 3'd5;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sys_ctrl_rx_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sys_ctrl_rx #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  ev_t  exp_q[$];
  int   tx_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   full_push = 0;
  logic full_at_edge = 1'b0;

  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  function automatic void observe(ev_t obs);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", 32'(obs), 32'h0);
    end else begin
      e = exp_q.pop_front();
      chk("event", 32'(obs), 32'(e));
    end
  endfunction

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    full_at_edge <= bus.tx_full;
  end

  always @(negedge clk) begin
    if (bus.rf_wr_en)  observe({EV_WR, 8'(bus.rf_addr), bus.rf_wr_data});
    if (bus.rf_rd_en)  observe({EV_RD, 8'(bus.rf_addr), 8'h00});
    if (bus.alu_en)    observe({EV_ALU, 8'(bus.alu_fun), 8'h00});
    if (bus.frame_err) observe({EV_ERR, 16'h0000});
    if (bus.tx_wr_en) begin
      observe({EV_TX, 8'h00, bus.tx_wr_data});
      tx_cyc.push_back(cyc);
      if (full_at_edge) full_push++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data       = b;
    bus.rx_data_valid = 1'b1;
    tick();
    bus.rx_data_valid = 1'b0;
  endtask

  task automatic expect_ev(input logic [2:0] k, input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({k, a, d});
  endtask

  task automatic alu_resp(input logic [15:0] r);
    bus.alu_out       = r;
    bus.alu_out_valid = 1'b1;
    tick();
    bus.alu_out_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, 32'(bus.busy), 32'h0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rf_wr_en"},   32'(bus.rf_wr_en),   32'h0);
    chk({tag, "_rf_rd_en"},   32'(bus.rf_rd_en),   32'h0);
    chk({tag, "_rf_addr"},    32'(bus.rf_addr),    32'h0);
    chk({tag, "_rf_wr_data"}, 32'(bus.rf_wr_data), 32'h0);
    chk({tag, "_alu_en"},     32'(bus.alu_en),     32'h0);
    chk({tag, "_alu_fun"},    32'(bus.alu_fun),    32'h0);
    chk({tag, "_tx_wr_en"},   32'(bus.tx_wr_en),   32'h0);
    chk({tag, "_tx_wr_data"}, 32'(bus.tx_wr_data), 32'h0);
    chk({tag, "_busy"},       32'(bus.busy),       32'h0);
    chk({tag, "_frame_err"},  32'(bus.frame_err),  32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end of the sequence");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    int d;
    bus.rx_data       = '0;
    bus.rx_data_valid = 1'b0;
    bus.rf_rd_data    = '0;
    bus.rf_rd_valid   = 1'b0;
    bus.alu_out       = '0;
    bus.alu_out_valid = 1'b0;
    bus.tx_full       = 1'b0;
    rstn = 1'b0;
    repeat (3) tick();
    chk_outputs_zero("reset");
    rstn = 1'b1;
    tick();

    // Register write: AA 05 3C
    expect_ev(EV_WR, 8'h05, 8'h3C);
    send(8'hAA); send(8'h05); send(8'h3C);
    chk("wr_latency", 32'(bus.rf_wr_en), 32'h1);
    chk("wr_busy_after", 32'(bus.busy), 32'h0);
    tick();
    chk("wr_one_cycle", 32'(bus.rf_wr_en), 32'h0);

    // Register read: BB 07, data returned two cycles after the strobe
    expect_ev(EV_RD, 8'h07, 8'h00);
    send(8'hBB); send(8'h07);
    chk("rd_latency", 32'(bus.rf_rd_en), 32'h1);
    chk("rd_busy", 32'(bus.busy), 32'h1);
    tick(); tick();
    expect_ev(EV_TX, 8'h00, 8'h5A);
    bus.rf_rd_data  = 8'h5A;
    bus.rf_rd_valid = 1'b1;
    tick();
    bus.rf_rd_valid = 1'b0;
    chk("rd_tx_latency", 32'(bus.tx_wr_en), 32'h1);
    chk("rd_tx_data", 32'(bus.tx_wr_data), 32'h5A);
    tick();
    chk("rd_single_push", 32'(bus.tx_wr_en), 32'h0);
    wait_idle("rd");

    // ALU with operands: CC 12 34 00, result 0x0046
    expect_ev(EV_WR, 8'h00, 8'h12);
    expect_ev(EV_WR, 8'h01, 8'h34);
    expect_ev(EV_ALU, 8'h00, 8'h00);
    send(8'hCC); send(8'h12);
    chk("opa_addr", 32'(bus.rf_addr), 32'h0);
    send(8'h34);
    chk("opb_addr", 32'(bus.rf_addr), 32'h1);
    send(8'h00);
    chk("alu_latency", 32'(bus.alu_en), 32'h1);
    tick(); tick();
    expect_ev(EV_TX, 8'h00, 8'h46);
    expect_ev(EV_TX, 8'h00, 8'h00);
    alu_resp(16'h0046);
    chk("alu_tx_lsb_en", 32'(bus.tx_wr_en), 32'h1);
    chk("alu_tx_lsb", 32'(bus.tx_wr_data), 32'h46);
    tick();
    chk("alu_tx_msb_en", 32'(bus.tx_wr_en), 32'h1);
    chk("alu_tx_msb", 32'(bus.tx_wr_data), 32'h00);
    wait_idle("alu_ab");

    // ALU without operands, TX FIFO full for five cycles
    expect_ev(EV_ALU, 8'h02, 8'h00);
    send(8'hDD); send(8'h02);
    chk("alu_fun", 32'(bus.alu_fun), 32'h2);
    tick();
    bus.tx_full = 1'b1;
    expect_ev(EV_TX, 8'h00, 8'hEF);
    expect_ev(EV_TX, 8'h00, 8'hBE);
    alu_resp(16'hBEEF);
    repeat (4) tick();
    chk("full_hold_no_push", 32'(bus.tx_wr_en), 32'h0);
    chk("full_hold_busy", 32'(bus.busy), 32'h1);
    n0 = tx_cyc.size();
    bus.tx_full = 1'b0;
    tick(); tick(); tick();
    d = (tx_cyc.size() >= n0 + 2) ? (tx_cyc[n0+1] - tx_cyc[n0]) : -1;
    chk("full_release_consecutive", 32'(d), 32'h1);
    wait_idle("alu");

    // Unknown opcode
    expect_ev(EV_ERR, 8'h00, 8'h00);
    send(8'h55);
    chk("err_pulse", 32'(bus.frame_err), 32'h1);
    chk("err_busy", 32'(bus.busy), 32'h0);
    tick();
    chk("err_one_cycle", 32'(bus.frame_err), 32'h0);

    // Reset in the middle of a CC frame, then a clean write
    expect_ev(EV_WR, 8'h00, 8'h12);
    send(8'hCC); send(8'h12);
    tick();
    rstn = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    tick();
    rstn = 1'b1;
    tick();
    expect_ev(EV_WR, 8'h03, 8'h99);
    send(8'hAA); send(8'h03); send(8'h99);
    chk("post_reset_wr", 32'(bus.rf_wr_en), 32'h1);
    chk("post_reset_addr", 32'(bus.rf_addr), 32'h3);
    wait_idle("post_reset");

`ifdef SYS_CTRL_TIMEOUT_EN
    // Partial frame abandoned by the inter-byte timeout
    expect_ev(EV_ERR, 8'h00, 8'h00);
    send(8'hAA);
    chk("to_busy_wait", 32'(bus.busy), 32'h1);
    repeat (TO + 4) tick();
    chk("to_idle", 32'(bus.busy), 32'h0);
`endif

    repeat (5) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    chk("no_push_while_full", 32'(full_push), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sys_ctrl_rx.md
Name: sys_ctrl_rx

Overview:
- Command sequencer downstream of the UART receiver.
- Consumes the byte stream (parallel byte + one-cycle valid pulse from the RX FSM) and decodes multi-byte command frames.
- Drives register-file write/read, ALU operand load and operation start.
- Pushes read-back/ALU results into the TX FIFO, holding them while the FIFO is full.

Parameters:
- ADDR_W, 4, register-file address width (rx byte bits [ADDR_W-1:0] used).
- DATA_W, 8, byte width; ALU result is 2*DATA_W.
- TIMEOUT_CYCLES, 1023, inter-byte timeout (used only with SYS_CTRL_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- rx_data  in  DATA_W  received byte
- rx_data_valid  in  1  one-cycle pulse, rx_data valid
- rf_wr_en  out  1  register-file write strobe (1 cycle)
- rf_rd_en  out  1  register-file read strobe (1 cycle)
- rf_addr  out  ADDR_W  register-file address
- rf_wr_data  out  DATA_W  register-file write data
- rf_rd_data  in  DATA_W  read data
- rf_rd_valid  in  1  read data valid (>=1 cycle after rf_rd_en)
- alu_en  out  1  ALU start strobe (1 cycle)
- alu_fun  out  4  ALU function code
- alu_out  in  2*DATA_W  ALU result
- alu_out_valid  in  1  ALU result valid pulse
- tx_wr_en  out  1  TX FIFO push strobe
- tx_wr_data  out  DATA_W  TX FIFO push data
- tx_full  in  1  TX FIFO full
- busy  out  1  high in any state except IDLE
- frame_err  out  1  one-cycle pulse on unknown opcode (or timeout when enabled)

Behaviour:
- Reset: clk domain, async assert on rstn low, state=IDLE. All strobes 0; rf_addr, rf_wr_data, alu_fun, tx_wr_data, busy, frame_err all 0.
- Opcodes (first byte in IDLE):
  - 0xAA: write {addr, data}
  - 0xBB: read {addr}
  - 0xCC: ALU with operands {A, B, fun}
  - 0xDD: ALU without operands {fun}
- Any other opcode in IDLE: frame_err pulses the following cycle; state stays IDLE.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_LSB, TX_MSB.
- 0xAA: IDLE->WR_ADDR. On the byte, latch rf_addr -> WR_DATA. On the next byte, rf_wr_data=byte, rf_wr_en=1 for one cycle -> IDLE.
- 0xBB: IDLE->RD_ADDR. On the byte, latch rf_addr, rf_rd_en=1 one cycle -> RD_WAIT.
  - RD_WAIT: on rf_rd_valid, latch rf_rd_data into the result LSB -> TX_MSB with a single-byte flag set. Read returns one byte only.
- 0xCC: IDLE->OP_A. On byte: write to rf_addr=0, one-cycle rf_wr_en -> OP_B. On byte: write to rf_addr=1 -> ALU_FUN.
- 0xDD: IDLE->ALU_FUN directly.
- ALU_FUN: on byte, alu_fun=byte[3:0], alu_en=1 one cycle -> ALU_WAIT.
- ALU_WAIT: on alu_out_valid, latch alu_out -> TX_LSB.
- TX_LSB: when !tx_full, tx_wr_en=1 with low byte -> TX_MSB. While tx_full, hold with no push.
- TX_MSB: when !tx_full, push the high byte, or the read byte for reads -> IDLE.
- Each push is exactly one cycle. tx_wr_data is registered and stable while tx_wr_en is high.
- rx_data_valid in RD_WAIT, ALU_WAIT, TX_LSB, TX_MSB: byte dropped, no error. Commands are not pipelined.
- rx_data_valid coinciding with alu_out_valid/rf_rd_valid: response takes priority; the byte is dropped.
- Latency: rf_wr_en/rf_rd_en/alu_en assert the cycle after the final rx_data_valid. First TX push occurs the cycle after the result is valid if tx_full=0.
- Reset mid-frame: return to IDLE, partial frame discarded, no strobes.
- All outputs registered. The next-state block is combinational, with a default of IDLE for illegal encodings.

Optional Feature:
- Macro SYS_CTRL_TIMEOUT_EN.
- Defined:
  - A counter clears on every rx_data_valid and on entry to a byte-waiting state (WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUN).
  - When it reaches TIMEOUT_CYCLES in such a state: frame_err pulses, state goes to IDLE, no strobes issued.
  - Wait states for rd/alu results are not timed.
- Undefined: no counter logic; partial frames wait indefinitely.

Decomposition:
- Package sys_ctrl_pkg: state enum, opcode constants (0xAA/0xBB/0xCC/0xDD), operand addresses (0,1).
- Sub-module tx_byte_pusher: takes a 1-or-2-byte payload plus a start pulse; sequences the LSB/MSB pushes against tx_full; returns a done pulse.

Test Plan:
- AA,05,3C -> rf_wr_en one cycle with rf_addr=5, rf_wr_data=0x3C; state IDLE after; no tx_wr_en.
- BB,07, rf_rd_data=0x5A after 2 cycles -> rf_rd_en with addr 7, then exactly one tx push 0x5A.
- CC,12,34,00, alu_out=0x0046 -> writes 0x12@0, 0x34@1; alu_en with fun=0; pushes 0x46 then 0x00.
- DD,02, alu_out=0xBEEF, tx_full high 5 cycles -> no push while full; then 0xEF, 0xBE on consecutive cycles.
- Byte 0x55 in IDLE -> frame_err one cycle, busy stays 0. rstn low mid CC frame -> all outputs 0, next AA frame decodes normally.
- With SYS_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16: AA then silence 16 cycles -> frame_err pulse, IDLE, no rf_wr_en.
